// File: rtl/blink_pkg.sv
// Shared types and constants for the multi-channel blink generator.
package blink_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 2'b00,
        MODE_STEADY = 2'b01,
        MODE_SLOW   = 2'b10,
        MODE_FAST   = 2'b11
    } mode_t;

endpackage

// File: rtl/blink_channel.sv
// One blink channel: frame counter with wrap, restart, mode decode and registered visible flag.
module blink_channel
    import blink_pkg::*;
#(
    parameter int CNT_W         = 6,
    parameter int PERIOD_FRAMES = 64,
    parameter int ON_FRAMES     = 32
) (
    input  logic  clk,
    input  logic  clr_n,
    input  logic  tick,
    input  logic  restart,
    input  mode_t mode,
    output logic  blink_on
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_FRAMES - 1);
    localparam logic [CNT_W-1:0] SLOW_ON  = CNT_W'(ON_FRAMES);
    localparam logic [CNT_W-1:0] HALF_PER = CNT_W'(PERIOD_FRAMES / 2);
    localparam logic [CNT_W-1:0] FAST_ON  = CNT_W'((ON_FRAMES / 2 == 0) ? 1 : ON_FRAMES / 2);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             blink_on_reg;
    logic             on_next;

    // Restart outranks a coincident tick so a moved cursor shows at once.
    always_comb begin
        cnt_next = cnt_reg;
        if (restart) begin
            cnt_next = '0;
        end else if (tick) begin
            cnt_next = (cnt_reg == LAST_CNT) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_comb begin
        on_next = 1'b0;
        case (mode)
            MODE_OFF:    on_next = 1'b0;
            MODE_STEADY: on_next = 1'b1;
            MODE_SLOW:   on_next = (cnt_next < SLOW_ON);
            MODE_FAST:   on_next = ((cnt_next % HALF_PER) < FAST_ON);
            default:     on_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_reg      <= '0;
            blink_on_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            blink_on_reg <= on_next;
        end
    end

    assign blink_on = blink_on_reg;

endmodule

// File: rtl/blink_generator.sv
// Multi-channel blink generator on the pixel clock; frame tick is the vblank rising edge.
module blink_generator
    import blink_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int CNT_W         = 6,
    parameter int PERIOD_FRAMES = 64,
    parameter int ON_FRAMES     = 32
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     vblank,
    input  logic [NUM_CH-1:0]        restart,
    input  logic [MODE_W*NUM_CH-1:0] mode,
    output logic [NUM_CH-1:0]        blink_on,
    output logic                     frame_tick
);

    if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
        $error("blink_generator: NUM_CH must be 1..8");
    end
    if ((PERIOD_FRAMES % 2 != 0) || (PERIOD_FRAMES < 2) || (PERIOD_FRAMES > (1 << CNT_W))) begin : g_bad_period
        $error("blink_generator: PERIOD_FRAMES must be even and in 2..2**CNT_W");
    end
    if ((ON_FRAMES < 1) || (ON_FRAMES >= PERIOD_FRAMES)) begin : g_bad_on
        $error("blink_generator: ON_FRAMES must be 1..PERIOD_FRAMES-1");
    end

    logic vb_d_reg;
    logic frame_tick_reg;
    logic tick;

    assign tick = vblank & ~vb_d_reg;

    // Edge register resets high so vblank already high at release is not an edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vb_d_reg       <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            vb_d_reg       <= vblank;
            frame_tick_reg <= tick;
        end
    end

    assign frame_tick = frame_tick_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        blink_channel #(
            .CNT_W         (CNT_W),
            .PERIOD_FRAMES (PERIOD_FRAMES),
            .ON_FRAMES     (ON_FRAMES)
        ) u_channel (
            .clk      (clk),
            .clr_n    (clr_n),
            .tick     (tick),
            .restart  (restart[gi]),
            .mode     (mode_t'(mode[MODE_W*gi +: MODE_W])),
            .blink_on (blink_on[gi])
        );
    end

endmodule

// File: tb/tb_blink_generator.sv
// Scoreboard bench for blink_generator: frame-level reference model, random and directed stimulus.
module tb_blink_generator;

    localparam int NUM_CH = 2;
    localparam int PERIOD = 64;
    localparam int ONF    = 32;
    localparam int HALF   = PERIOD / 2;
    localparam int FAST_ON = (ONF / 2 == 0) ? 1 : ONF / 2;

    logic                  clk = 1'b0;
    logic                  clr_n = 1'b0;
    logic                  vblank = 1'b1;
    logic [NUM_CH-1:0]     restart = '0;
    logic [2*NUM_CH-1:0]   mode = '0;
    logic [NUM_CH-1:0]     blink_on;
    logic                  frame_tick;

    typedef struct {
        logic              tick;
        logic [NUM_CH-1:0] on;
        int                step_no;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_cnt[NUM_CH];
    logic m_vb_prev;
    int   step_no = 0;

    blink_generator #(
        .NUM_CH        (NUM_CH),
        .CNT_W         (6),
        .PERIOD_FRAMES (PERIOD),
        .ON_FRAMES     (ONF)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .vblank     (vblank),
        .restart    (restart),
        .mode       (mode),
        .blink_on   (blink_on),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic visible(input int frame, input logic [1:0] m);
        case (m)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return frame < ONF;
            default: return (frame % HALF) < FAST_ON;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        m_vb_prev = 1'b1;
    endfunction

    // Apply one cycle of inputs, predict the outputs after the next edge, advance one cycle.
    task automatic step(input logic vb, input logic [NUM_CH-1:0] rs, input logic [2*NUM_CH-1:0] md);
        exp_t e;
        logic t;
        vblank  = vb;
        restart = rs;
        mode    = md;
        t = vb && !m_vb_prev;
        m_vb_prev = vb;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rs[i]) m_cnt[i] = 0;
            else if (t) m_cnt[i] = (m_cnt[i] + 1) % PERIOD;
            e.on[i] = visible(m_cnt[i], md[2*i +: 2]);
        end
        e.tick = t;
        step_no++;
        e.step_no = step_no;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // One frame: vblank rises for one cycle, then low for a cycle.
    task automatic frame(input logic [2*NUM_CH-1:0] md);
        step(1'b1, '0, md);
        step(1'b0, '0, md);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (blink_on !== '0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL %s: blink_on=%b frame_tick=%b, need 0/0", tag, blink_on, frame_tick);
        end else begin
            $display("ok   %s: outputs cleared", tag);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare 1 time unit after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (blink_on !== e.on || frame_tick !== e.tick) begin
                    errors++;
                    $display("FAIL step %0d: blink_on=%b frame_tick=%b, need blink_on=%b frame_tick=%b",
                             e.step_no, blink_on, frame_tick, e.on, e.tick);
                end else begin
                    $display("step %0d: blink_on=%b frame_tick=%b", e.step_no, blink_on, frame_tick);
                end
            end
        end
    end

    initial begin
        logic [2*NUM_CH-1:0] md;
        logic [NUM_CH-1:0]   rs;
        logic                vb;

        model_reset();
        #3;
        check_reset_outputs("reset asserted");

        // Release with vblank high: no tick, ch0 SLOW visible one clk later.
        @(posedge clk);
        #2;
        clr_n = 1'b1;
        model_reset();
        md = {2'b11, 2'b10};
        for (int k = 0; k < 4; k++) step(1'b1, '0, md);
        step(1'b0, '0, md);

        // Two full periods plus: ch0 SLOW, ch1 FAST, covers the 63 -> 0 wrap.
        for (int f = 0; f < 2 * PERIOD + 4; f++) frame(md);

        // Bring ch0 to count 40, then restart it together with a tick.
        while (m_cnt[0] != 39) frame(md);
        step(1'b0, '0, md);
        step(1'b1, 2'b01, md);
        step(1'b0, '0, md);

        // Count 10: SLOW -> OFF -> SLOW without disturbing the counter.
        while (m_cnt[0] != 10) frame(md);
        step(1'b0, '0, {2'b11, 2'b00});
        step(1'b0, '0, {2'b11, 2'b00});
        step(1'b0, '0, md);
        frame(md);

        // Asynchronous clear mid-stream at count 50.
        while (m_cnt[0] != 50) frame(md);
        vblank = 1'b1;
        #1;
        clr_n = 1'b0;
        #1;
        check_reset_outputs("mid-stream clear");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        clr_n = 1'b1;
        step(1'b1, '0, md);
        step(1'b0, '0, md);
        frame(md);

        // Randomised traffic: irregular vblank, sparse restarts, occasional mode changes.
        for (int k = 0; k < 800; k++) begin
            vb = ($urandom_range(0, 2) == 0);
            rs = '0;
            for (int i = 0; i < NUM_CH; i++) rs[i] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) md = 4'($urandom);
            step(vb, rs, md);
        end

        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blink_generator.md
Name: blink_generator

Overview:
Multi-channel, parametrised successor to the single cursor blinker. Runs entirely on the pixel clock. It derives a one-cycle frame tick from the rising edge of the vblank level, so no vblank-as-clock is needed and restart is reliably synchronous. Each channel has its own frame counter, mode select and restart. Drives cursor blink, blinking-text attribute and similar consumers in the video pipeline.

Parameters:
NUM_CH, 2, number of independent blink channels (1..8)
CNT_W, 6, frame counter width per channel
PERIOD_FRAMES, 64, slow-blink period in frames; even, 2..2**CNT_W
ON_FRAMES, 32, slow-blink visible frames per period; 1..PERIOD_FRAMES-1

Ports:
clk  in  1  pixel clock
clr_n  in  1  asynchronous active-low reset
vblank  in  1  vertical blank level, synchronous to clk
restart  in  NUM_CH  per-channel synchronous restart (cursor moved, attribute rewritten)
mode  in  2*NUM_CH  per-channel mode; channel i uses bits [2i+1:2i]
blink_on  out  NUM_CH  per-channel visible flag, registered
frame_tick  out  1  one-cycle pulse on vblank rising edge, registered

Behaviour:
- Reset (clr_n low, asynchronous):
  - all counters = 0
  - blink_on = 0
  - frame_tick = 0
  - vblank edge register = 1, so a high vblank at reset release gives no spurious tick
- Edge detect:
  - vb_d <= vblank
  - tick = vblank & ~vb_d
  - frame_tick <= tick; it asserts in the cycle after the first clk edge that samples vblank high.
- Per-channel counter, next value cnt_nx, in priority order:
  - restart[i]: cnt_nx = 0. Wins over a simultaneous tick.
  - tick: cnt_nx = 0 if cnt == PERIOD_FRAMES-1, else cnt+1.
  - otherwise: hold.
  - The counter always runs; mode changes never reset it.
- Modes (constants in package):
  - MODE_OFF = 00: on = 0
  - MODE_STEADY = 01: on = 1
  - MODE_SLOW = 10: on = (cnt_nx < ON_FRAMES)
  - MODE_FAST = 11: on = ((cnt_nx mod (PERIOD_FRAMES/2)) < ON_FRAMES/2); if ON_FRAMES/2 == 0, use 1
- Output timing:
  - blink_on[i] <= on, computed from cnt_nx and the current mode.
  - A counter update and the corresponding blink_on change occur at the same clk edge.
  - A mode change is reflected one clk later.
- Restart: the visible phase starts at the edge that samples restart, so the cursor is shown immediately after a move in both blink modes.
- Wrap-around: PERIOD_FRAMES-1 followed by a tick goes to 0. Counts PERIOD_FRAMES..2**CNT_W-1 are unreachable.
- Simultaneous events:
  - Restart on several channels in one cycle is independent per channel.
  - A tick with restart active updates only the non-restarted channels.
- Reset mid-frame: state clears immediately. The next vblank rising edge after release counts as frame 1.
- Illegal parameters (odd PERIOD_FRAMES, ON_FRAMES >= PERIOD_FRAMES, PERIOD_FRAMES > 2**CNT_W) are rejected by an elaboration-time check.

Decomposition:
- Package blink_pkg holds:
  - mode typedef (2-bit enum MODE_OFF/STEADY/SLOW/FAST)
  - mode field width constant
- Sub-module blink_channel, instantiated NUM_CH times by generate:
  - inputs: clk, clr_n, tick, restart, mode
  - contains counter, wrap, mode decode and output register
- Top level holds only the vblank edge detector, frame_tick register and parameter checks.

Test Plan:
- Reset release with vblank held high: frame_tick stays 0, blink_on = 0; with mode=SLOW, blink_on = 1 one clk after release.
- Defaults, ch0 SLOW, 64 vblank pulses: blink_on[0] = 1 for ticks 0..31 and 0 for ticks 32..63, then repeats. The counter wraps 63 -> 0.
- ch1 FAST, 64 pulses: blink_on[1] = 1 for counts 0-15 and 32-47, and 0 for counts 16-31 and 48-63.
- ch0 at count 40 (off): assert restart[0] in the same cycle as a tick -> count = 0 and blink_on[0] = 1 at that edge; ch1 still advances.
- Switch ch0 from SLOW to OFF at count 10 -> blink_on[0] = 0 one clk later; switch back to SLOW -> count continues from 10 and blink_on = 1.
- Assert clr_n low mid-stream with count 50 -> blink_on and frame_tick go to 0 immediately, count = 0. After release, the first vblank rising edge gives count 1.
